lstm_bptt_seq: RTL and testbench

Sequential, parametrised LSTM backpropagation-through-time engine. It accepts one timestep of forward-pass state per handshake, last timestep first. For each step it computes the gate deltas and carries dh/dc/f backward to the earlier step. It accumulates weight, bias and cost gradients in registers. It replaces the fully unrolled combinational bp datapath with a time-multiplexed one, so cost is independent of TIMESTEP, and sits between the forward-pass state buffer and the weight-update stage.

---
 rtl/lstm_bptt_seq.sv | 162 ++++++++++++++++
 tb/tb_lstm_bptt_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_bptt_seq.sv
// Time-multiplexed LSTM backprop-through-time engine: one timestep per handshake, last step first.
// Gate deltas are computed once per step; four per-gate lanes fold weight/bias gradients over NUM ACC cycles.
module lstm_bptt_seq #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24,
  parameter int TIMESTEP = 4,
  parameter int NUM      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [NUM*WIDTH-1:0]  i_x,
  input  logic [WIDTH-1:0]      i_t,
  input  logic [WIDTH-1:0]      i_h,
  input  logic [WIDTH-1:0]      i_c,
  input  logic [WIDTH-1:0]      i_tc,
  input  logic [WIDTH-1:0]      i_c_prev,
  input  logic [WIDTH-1:0]      i_a,
  input  logic [WIDTH-1:0]      i_i,
  input  logic [WIDTH-1:0]      i_f,
  input  logic [WIDTH-1:0]      i_o,
  input  logic [NUM*WIDTH-1:0]  i_wa,
  input  logic [NUM*WIDTH-1:0]  i_wi,
  input  logic [NUM*WIDTH-1:0]  i_wf,
  input  logic [NUM*WIDTH-1:0]  i_wo,
  output logic [4*WIDTH-1:0]    o_b,
  output logic [NUM*WIDTH-1:0]  o_wa,
  output logic [NUM*WIDTH-1:0]  o_wi,
  output logic [NUM*WIDTH-1:0]  o_wf,
  output logic [NUM*WIDTH-1:0]  o_wo,
  output logic [WIDTH-1:0]      o_cost,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int KW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int CW = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

  typedef enum logic [2:0] {IDLE, RECV, DELTA, GATE, ACC, DONE} state_t;

  function automatic logic [WIDTH-1:0] mul(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q);
    logic signed [2*WIDTH-1:0] pr;
    pr = $signed({{WIDTH{p[WIDTH-1]}}, p}) * $signed({{WIDTH{q[WIDTH-1]}}, q});
    return pr[FRAC+WIDTH-1:FRAC];
  endfunction

  state_t state, nstate;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k;
  logic [NUM-1:0][WIDTH-1:0] x;
  logic [WIDTH-1:0] s_t, s_h, s_tc, s_cp, s_a, s_i, s_f, s_o;
  logic [WIDTH-1:0] dc, dh_n, dc_n, f_n, cost;
  // gate order a,i,f,o matches the o_b packing (a in the LSBs)
  logic [3:0][WIDTH-1:0] dg, hterm, bacc;
  logic [3:0][NUM-1:0][WIDTH-1:0] wv, wacc;
  logic [WIDTH-1:0] e, dh_w, e2;
  logic start_ok, last_k, last_t;
  logic unused_bits;

  assign wv[0] = i_wa;
  assign wv[1] = i_wi;
  assign wv[2] = i_wf;
  assign wv[3] = i_wo;
  assign unused_bits = ^{i_c, i_wa, i_wi, i_wf, i_wo};

  assign e        = s_h - s_t;
  assign dh_w     = e + dh_n;
  assign e2       = mul(e, e);
  assign start_ok = (state == IDLE) && i_start;
  assign last_k   = (k == KW'(NUM-1));
  assign last_t   = (cnt == CW'(TIMESTEP-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (i_start) nstate = RECV;
      RECV:    if (i_valid) nstate = DELTA;
      DELTA:   nstate = GATE;
      GATE:    nstate = ACC;
      ACC:     if (last_k) nstate = last_t ? DONE : RECV;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == RECV);
    o_busy  = (state != IDLE);
    o_done  = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; k <= '0; x <= '0;
      s_t <= '0; s_h <= '0; s_tc <= '0; s_cp <= '0;
      s_a <= '0; s_i <= '0; s_f <= '0; s_o <= '0;
      dc <= '0; dg <= '0; dh_n <= '0; dc_n <= '0; f_n <= '0; cost <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          cnt <= '0; k <= '0; dh_n <= '0; dc_n <= '0; f_n <= '0; cost <= '0;
        end
        RECV: if (i_valid) begin
          x <= i_x; s_t <= i_t; s_h <= i_h; s_tc <= i_tc; s_cp <= i_c_prev;
          s_a <= i_a; s_i <= i_i; s_f <= i_f; s_o <= i_o;
        end
        DELTA: begin
          dc    <= mul(mul(dh_w, s_o), ONE - mul(s_tc, s_tc)) + mul(dc_n, f_n);
          dg[3] <= mul(mul(dh_w, s_tc), mul(s_o, ONE - s_o));
          cost  <= cost + {e2[WIDTH-1], e2[WIDTH-1:1]};
        end
        GATE: begin
          dg[0] <= mul(mul(dc, s_i), ONE - mul(s_a, s_a));
          dg[1] <= mul(mul(dc, s_a), mul(s_i, ONE - s_i));
          dg[2] <= mul(mul(dc, s_cp), mul(s_f, ONE - s_f));
        end
        ACC: begin
          k <= last_k ? '0 : k + 1'b1;
          // carries for the earlier timestep, taken once the deltas are settled
          if (k == '0) begin
            dh_n <= hterm[0] + hterm[1] + hterm[2] + hterm[3];
            dc_n <= dc;
            f_n  <= s_f;
          end
          if (last_k && !last_t) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [WIDTH-1:0] b;
    logic [NUM-1:0][WIDTH-1:0] w;
    assign hterm[g] = mul(wv[g][NUM-1], dg[g]);
    assign bacc[g]  = b;
    assign wacc[g]  = w;
    always_ff @(posedge clk) begin
      if (rst || start_ok) begin
        b <= '0;
        w <= '0;
      end else if (state == ACC) begin
        w[k] <= w[k] + mul(dg[g], x[k]);
        if (k == '0) b <= b + dg[g];
      end
    end
  end

  assign o_b    = bacc;
  assign o_wa   = wacc[0];
  assign o_wi   = wacc[1];
  assign o_wf   = wacc[2];
  assign o_wo   = wacc[3];
  assign o_cost = cost;
endmodule

// File: tb/tb_lstm_bptt_seq.sv
// Bench for lstm_bptt_seq: directed sequences, final gradients checked against a queued reference model.
module tb_lstm_bptt_seq;
  localparam int W = 32, F = 24, TS = 4, N = 2;
  localparam logic [W-1:0] ONE = 32'h0100_0000;

  typedef struct packed {
    logic [W-1:0] t, h, c, tc, cp, a, i, f, o;
    logic [N-1:0][W-1:0] x;
  } step_t;
  typedef struct packed {
    logic [4*W-1:0] b;
    logic [N*W-1:0] wa, wi, wf, wo;
    logic [W-1:0]   cost;
  } res_t;

  logic clk = 1'b0;
  logic rst, i_start, i_valid, o_ready, o_busy, o_done;
  logic [N*W-1:0] i_x, i_wa, i_wi, i_wf, i_wo, o_wa, o_wi, o_wf, o_wo;
  logic [W-1:0] i_t, i_h, i_c, i_tc, i_c_prev, i_a, i_i, i_f, i_o, o_cost;
  logic [4*W-1:0] o_b;

  always #5 clk = ~clk;

  lstm_bptt_seq #(.WIDTH(W), .FRAC(F), .TIMESTEP(TS), .NUM(N)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .o_ready(o_ready),
    .i_x(i_x), .i_t(i_t), .i_h(i_h), .i_c(i_c), .i_tc(i_tc), .i_c_prev(i_c_prev),
    .i_a(i_a), .i_i(i_i), .i_f(i_f), .i_o(i_o),
    .i_wa(i_wa), .i_wi(i_wi), .i_wf(i_wf), .i_wo(i_wo),
    .o_b(o_b), .o_wa(o_wa), .o_wi(o_wi), .o_wf(o_wf), .o_wo(o_wo),
    .o_cost(o_cost), .o_busy(o_busy), .o_done(o_done)
  );

  int checks = 0, errors = 0;
  res_t exp_q[$];
  res_t last_exp, mon_ex;
  logic [3:0][N-1:0][W-1:0] wts;
  logic [3:0][W-1:0] mb;
  logic [3:0][N-1:0][W-1:0] mw;
  logic [W-1:0] mcost, mdh, mdc, mf;

  assign i_wa = wts[0];
  assign i_wi = wts[1];
  assign i_wf = wts[2];
  assign i_wo = wts[3];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mul(input logic [W-1:0] p, input logic [W-1:0] q);
    longint pr;
    pr = longint'($signed(p)) * longint'($signed(q));
    return W'(pr >>> F);
  endfunction

  task automatic model_reset();
    mb = '0; mw = '0; mcost = '0; mdh = '0; mdc = '0; mf = '0;
  endtask

  task automatic model_step(input step_t s);
    logic [W-1:0] e, dh, dc, m, hs;
    logic [3:0][W-1:0] d;
    e  = s.h - s.t;
    dh = e + mdh;
    dc = mul(mul(dh, s.o), ONE - mul(s.tc, s.tc)) + mul(mdc, mf);
    d[3] = mul(mul(dh, s.tc), mul(s.o, ONE - s.o));
    d[0] = mul(mul(dc, s.i), ONE - mul(s.a, s.a));
    d[1] = mul(mul(dc, s.a), mul(s.i, ONE - s.i));
    d[2] = mul(mul(dc, s.cp), mul(s.f, ONE - s.f));
    m = mul(e, e);
    mcost = mcost + W'($signed(m) >>> 1);
    hs = '0;
    for (int g = 0; g < 4; g++) begin
      mb[g] = mb[g] + d[g];
      for (int j = 0; j < N; j++) mw[g][j] = mw[g][j] + mul(d[g], s.x[j]);
      hs = hs + mul(wts[g][N-1], d[g]);
    end
    mdh = hs; mdc = dc; mf = s.f;
  endtask

  task automatic push_exp();
    last_exp.b = mb; last_exp.wa = mw[0]; last_exp.wi = mw[1];
    last_exp.wf = mw[2]; last_exp.wo = mw[3]; last_exp.cost = mcost;
    exp_q.push_back(last_exp);
  endtask

  function automatic step_t rnd_step();
    step_t s;
    s.h  = 32'h7FFF_0000 | 32'($urandom_range(0, 65535));
    s.t  = 32'h8000_0000 | 32'($urandom_range(0, 65535));
    s.c  = $urandom; s.tc = $urandom; s.cp = $urandom; s.a = $urandom;
    s.i  = $urandom; s.f  = $urandom; s.o  = $urandom;
    s.x[0] = $urandom; s.x[1] = $urandom;
    return s;
  endfunction

  task automatic apply(input step_t s);
    i_t = s.t; i_h = s.h; i_c = s.c; i_tc = s.tc; i_c_prev = s.cp;
    i_a = s.a; i_i = s.i; i_f = s.f; i_o = s.o; i_x = s.x;
  endtask

  // called just after a rising edge; returns just after a rising edge
  task automatic start_seq();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send(input step_t s, input bit bp);
    int n;
    bit stalled;
    n = 0; stalled = 1'b0;
    apply(s);
    forever begin
      i_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bp) i_start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) chk("stall_hold_ready", o_ready, 1);
      if (o_ready && i_valid) break;
      stalled = o_ready;
      n++;
      if (n >= 80) begin
        chk("send_timeout", o_ready & i_valid, 1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_start = 1'b0;
    apply(rnd_step());
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_ready && n < 30);
    chk(tag, o_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_done && n < 40);
    chk(tag, o_done, 1);
  endtask

  always @(negedge clk) begin
    if (o_done) begin
      if (exp_q.size() == 0) chk("spurious_done", o_done, 0);
      else begin
        mon_ex = exp_q.pop_front();
        chk("fin_b", o_b, mon_ex.b);
        chk("fin_wa", o_wa, mon_ex.wa);
        chk("fin_wi", o_wi, mon_ex.wi);
        chk("fin_wf", o_wf, mon_ex.wf);
        chk("fin_wo", o_wo, mon_ex.wo);
        chk("fin_cost", o_cost, mon_ex.cost);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step_t s1, s2, sz;
    step_t rs [TS];
    rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; wts = '0;
    sz = '0;
    apply(sz);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", o_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_b", o_b, 0);
    chk("rst_wa", o_wa, 0);
    chk("rst_wo", o_wo, 0);
    chk("rst_cost", o_cost, 0);
    @(posedge clk); #1;

    // spec example: single step then recurrent carry into the second step
    s1 = '0;
    s1.h = 32'h0080_0000; s1.o = ONE; s1.a = 32'h0080_0000; s1.i = ONE;
    s1.f = 32'h0080_0000; s1.cp = ONE; s1.x[0] = ONE;
    s2 = '0;
    s2.h = 32'h0012_3456; s2.t = 32'h0012_3456; s2.o = ONE; s2.i = ONE;
    wts = '0; wts[0][N-1] = ONE;
    model_reset();
    model_step(s1); model_step(s2); model_step(sz); model_step(sz);
    push_exp();
    start_seq();
    send(s1, 1'b0);
    wait_ready("step1_ready");
    chk("step1_b", o_b, {32'h0, 32'h0020_0000, 32'h0, 32'h0060_0000});
    chk("step1_wa", o_wa, {32'h0, 32'h0060_0000});
    chk("step1_wf", o_wf, {32'h0, 32'h0020_0000});
    chk("step1_cost", o_cost, 32'h0020_0000);
    send(s2, 1'b0);
    wait_ready("step2_ready");
    chk("step2_ba", o_b[31:0], 32'h0100_0000);
    send(sz, 1'b0);
    send(sz, 1'b0);
    wait_done("spec_done");
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    chk("done_start_busy", o_busy, 0);
    chk("done_start_ready", o_ready, 0);
    repeat (3) @(negedge clk);
    chk("hold_b", o_b, last_exp.b);
    chk("hold_cost", o_cost, last_exp.cost);
    @(posedge clk); #1;

    // same sequence under random backpressure and stray i_start
    model_reset();
    model_step(s1); model_step(s2); model_step(sz); model_step(sz);
    push_exp();
    start_seq();
    send(s1, 1'b1);
    send(s2, 1'b1);
    send(sz, 1'b1);
    send(sz, 1'b1);
    wait_done("bp_done");
    @(posedge clk); #1;

    // wrap-around stress with large error terms and random weights
    for (int g = 0; g < 4; g++)
      for (int j = 0; j < N; j++) wts[g][j] = $urandom;
    for (int s = 0; s < TS; s++) rs[s] = rnd_step();
    model_reset();
    for (int s = 0; s < TS; s++) model_step(rs[s]);
    push_exp();
    start_seq();
    for (int s = 0; s < TS; s++) send(rs[s], 1'b0);
    wait_done("wrap_done");
    @(posedge clk); #1;

    // reset mid-sequence aborts without o_done
    start_seq();
    send(rnd_step(), 1'b0);
    wait_ready("abort_ready");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready0", o_ready, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_b", o_b, 0);
    chk("abort_wa", o_wa, 0);
    chk("abort_wi", o_wi, 0);
    chk("abort_wf", o_wf, 0);
    chk("abort_wo", o_wo, 0);
    chk("abort_cost", o_cost, 0);
    @(posedge clk); #1;

    // latency with i_valid held high
    wts = '0; wts[0][N-1] = ONE;
    model_reset();
    for (int s = 0; s < TS; s++) model_step(s1);
    push_exp();
    apply(s1);
    i_start = 1'b1; i_valid = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      chk($sformatf("lat_ready_c%0d", c), o_ready, (c == 1 || c == 6 || c == 11 || c == 16));
      chk($sformatf("lat_done_c%0d", c), o_done, (c == 21));
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
